// File: rtl/vend_dispenser.sv
// Vending dispense sequencer: latches credit on a vend request, then pulses
// the item actuator, pays change coin by coin and requests a credit clear.
// Ports:
//   clock_50MHz - system clock, rising edge
//   RSTb        - synchronous active-low reset
//   sflipflop   - current credit in nickel units (0..15)
//   vend_req    - single-cycle vend request, accepted only in IDLE
//   busy        - high whenever the sequencer is not IDLE
//   deny        - one-cycle pulse when credit is below PRICE
//   item_out    - item actuator pulse
//   coin_out    - coin actuator pulse
//   coin_sel    - coin for the current pulse (1 nickel, 2 dime, 3 quarter)
//   credit_clr  - one-cycle pulse at the end of a successful vend
module vend_dispenser #(
    parameter int PRICE        = 7,
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2
) (
    input  logic       clock_50MHz,
    input  logic       RSTb,
    input  logic [3:0] sflipflop,
    input  logic       vend_req,
    output logic       busy,
    output logic       deny,
    output logic       item_out,
    output logic       coin_out,
    output logic [1:0] coin_sel,
    output logic       credit_clr
);

    localparam int TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    // Timer counts down to zero, so it only needs to hold TMAX-1.
    localparam int TW = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [3:0]    PRICE_N = 4'(PRICE);
    localparam logic [TW-1:0] T_PULSE = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] T_GAP   = TW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ITEM,
        ITEM_GAP,
        COIN,
        COIN_GAP,
        DONE
    } state_t;

    state_t        state, state_d;
    logic [3:0]    cred, cred_d;
    logic [3:0]    chg, chg_d;
    logic [TW-1:0] timer, timer_d;

    logic       busy_d;
    logic       deny_d;
    logic       item_d;
    logic       coin_d;
    logic [1:0] sel_d;
    logic       clr_d;

    always_ff @(posedge clock_50MHz) begin
        if (!RSTb) begin
            state      <= IDLE;
            cred       <= '0;
            chg        <= '0;
            timer      <= '0;
            busy       <= 1'b0;
            deny       <= 1'b0;
            item_out   <= 1'b0;
            coin_out   <= 1'b0;
            coin_sel   <= 2'd0;
            credit_clr <= 1'b0;
        end else begin
            state      <= state_d;
            cred       <= cred_d;
            chg        <= chg_d;
            timer      <= timer_d;
            busy       <= busy_d;
            deny       <= deny_d;
            item_out   <= item_d;
            coin_out   <= coin_d;
            coin_sel   <= sel_d;
            credit_clr <= clr_d;
        end
    end

    // Outputs are computed for the state being entered and registered
    // alongside it, so every output is a clean flop output.
    always_comb begin
        state_d = state;
        cred_d  = cred;
        chg_d   = chg;
        timer_d = timer;
        deny_d  = 1'b0;
        item_d  = 1'b0;
        coin_d  = 1'b0;
        sel_d   = 2'd0;
        clr_d   = 1'b0;

        unique case (state)
            IDLE: begin
                if (vend_req) begin
                    cred_d  = sflipflop;
                    state_d = CHECK;
                    // deny lines up with the CHECK cycle.
                    deny_d  = (sflipflop < PRICE_N);
                end
            end
            CHECK: begin
                if (cred < PRICE_N) begin
                    state_d = IDLE;
                end else begin
                    chg_d   = cred - PRICE_N;
                    timer_d = T_PULSE;
                    item_d  = 1'b1;
                    state_d = ITEM;
                end
            end
            ITEM: begin
                if (timer == '0) begin
                    timer_d = T_GAP;
                    state_d = ITEM_GAP;
                end else begin
                    timer_d = timer - 1'b1;
                    item_d  = 1'b1;
                end
            end
            COIN: begin
                if (timer == '0) begin
                    timer_d = T_GAP;
                    state_d = COIN_GAP;
                end else begin
                    timer_d = timer - 1'b1;
                    coin_d  = 1'b1;
                    sel_d   = coin_sel;
                end
            end
            ITEM_GAP, COIN_GAP: begin
                if (timer != '0) begin
                    timer_d = timer - 1'b1;
                end else if (chg != 4'd0) begin
                    // Greedy pick made once on entry; coin_sel holds it.
                    if (chg >= 4'd5) begin
                        sel_d = 2'd3;
                        chg_d = chg - 4'd5;
                    end else if (chg >= 4'd2) begin
                        sel_d = 2'd2;
                        chg_d = chg - 4'd2;
                    end else begin
                        sel_d = 2'd1;
                        chg_d = chg - 4'd1;
                    end
                    coin_d  = 1'b1;
                    timer_d = T_PULSE;
                    state_d = COIN;
                end else begin
                    clr_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule
